hdmi_packet_stream_assembler: RTL and testbench
===============================================

// Module: hdmi_packet_stream_assembler
// PURPOSE
// Buffered, parametrised HDMI data-island packet serialiser with BCH ECC, placed between the packet picker and TMDS channel encoders.
// Accepts whole packets (header + 4 subpackets) over valid/ready into a small FIFO.
// Emits one packet per 32-pixel slot while data_island_period is high, with ECC computed on the fly.
// On FIFO underrun it inserts a null packet; it flags truncated packets.
// PARAMETERS
// ECC_POLY     8'h83  feedback mask of the LSB-first BCH ECC generator (HDMI: x^8+x^7+x^6+1 form)
// BUF_DEPTH    2      packet FIFO depth, legal 1..4
// NULL_HEADER  24'h0  header sent on underrun; null subpackets are all-zero
// PORTS
// clk_pixel           in   1      pixel clock
// reset               in   1      synchronous, active-high
// data_island_period  in   1      high for every pixel of a data island (guard bands excluded)
// in_valid            in   1      packet offered
// in_ready            out  1      FIFO can accept a packet
// in_header           in   24     HB2:HB1:HB0, HB0 in [7:0]
// in_sub              in   224    sub3:sub2:sub1:sub0, 56 bits each, sub0 in [55:0]
// packet_data         out  9      [0] header bit; [4:1] sub0..3 even bit; [8:5] sub0..3 odd bit
// counter             out  5      pixel index within current packet slot
// packet_start        out  1      high in the cycle with counter==0 inside island
// packets_sent        out  5      packets started in current island, saturates at 31
// underrun            out  1      1-cycle pulse: null packet inserted
// truncated           out  1      1-cycle pulse: island ended with counter!=0
// BEHAVIOUR
// - Reset: counter=0, FIFO empty, ECC regs=0, packets_sent=0, underrun=0, truncated=0, in_ready=1, packet_data=0.
// - Transfer on in_valid&&in_ready. in_ready = (fifo_count < BUF_DEPTH), registered state only, no pass-through.
// - counter: +1 per island cycle, wraps 31->0; forced to 0 in any cycle data_island_period is low.
// - Slot start: cycle with island && counter==0.
//   - cur = FIFO head if non-empty (pop at that edge), else {NULL_HEADER, 0}, with underrun pulsing the next cycle.
//   - cur is captured into the active register at that edge.
//   - packet_data in the counter==0 cycle is driven from cur combinationally.
// - Same-edge push and pop are legal; fifo_count is unchanged; order is FIFO.
// - bch4 = {ecc_h, header}; bchN = {ecc_N, subN}.
// - Pixel k outputs: [0]=bch4[k]; [1+N]=bchN[2k]; [5+N]=bchN[2k+1].
// - ECC update: e' = (e>>1) ^ ((e[0]^bit) ? ECC_POLY : 0), LSB first.
//   - Header ECC absorbs header[k] for k<24.
//   - Sub ECC absorbs 2 bits/cycle (2k then 2k+1) for k<28.
//   - ECC registers hold afterwards and are cleared at the edge where counter==31, or whenever island is low.
//   - Thus ecc_h is valid for k=24..31 and ecc_N for k=28..31, matching bit positions.
// - packet_data = 0 whenever data_island_period is low; latency 0 from counter, 0 from FIFO head at slot start.
// - packets_sent: +1 at each slot-start edge, saturating at 31; cleared when island low.
// - Island falls with counter!=0: the partial packet is dropped, not resent. truncated pulses for 1 cycle, and ECC/counter clear.
// - Reset mid-island: all state returns to reset values next cycle and queued packets are discarded.
// TESTING
// - Empty FIFO, 32-cycle island -> underrun pulse at cycle 1, packet_data=0 for all 32 cycles, packets_sent=1.
// - Push header 24'h0D0282, random subs, then 32-cycle island -> bits match the layout above.
//   ECC bits match the bit-serial model with poly 8'h83; packet_start only at cycle 0.
// - BUF_DEPTH=2: push 3 packets back-to-back -> in_ready low after the 2nd; the 3rd is accepted at the first slot start.
//   A 96-cycle island sends all 3 in order, with no underrun.
// - Island of 40 cycles with 1 queued packet -> 2nd slot is a null packet with underrun.
//   truncated pulses after the fall at counter=8; the next island restarts at counter=0.
// - Push during slot-start pop with fifo_count=1 -> count stays 1 and order is preserved.
// - Assert reset at counter=17 with 2 queued packets -> next cycle counter=0, FIFO empty, packet_data=0, in_ready=1.

Source files
------------

// File: rtl/hdmi_packet_stream_assembler.sv
`default_nettype none
// ============================================================================
// Module : hdmi_packet_stream_assembler
// Brief  : Buffered HDMI data-island packet serialiser. Whole packets are
//          queued in a small FIFO and emitted one per 32-pixel slot with
//          BCH ECC generated bit-serially. A null packet is inserted when
//          the FIFO is empty, and packets cut short by the island are flagged.
// Rev    : 1.0  initial release
// ============================================================================
module hdmi_packet_stream_assembler #(
  parameter logic [7:0]  ECC_POLY    = 8'h83,
  parameter int          BUF_DEPTH   = 2,      // legal range 1..4
  parameter logic [23:0] NULL_HEADER = 24'h0
) (
  input  logic         clk_pixel,
  input  logic         reset,
  input  logic         data_island_period,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [23:0]  in_header,
  input  logic [223:0] in_sub,
  output logic [8:0]   packet_data,
  output logic [4:0]   counter,
  output logic         packet_start,
  output logic [4:0]   packets_sent,
  output logic         underrun,
  output logic         truncated
);

  localparam int               PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
  localparam logic [2:0]       DEPTH_C  = 3'(BUF_DEPTH);
  localparam logic [4:0]       LAST_PIX = 5'd31;
  localparam logic [4:0]       HDR_BITS = 5'd24;
  localparam logic [4:0]       SUB_PAIRS = 5'd28;

  // One LSB-first step of the BCH generator.
  function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
    return (e >> 1) ^ ((e[0] ^ b) ? ECC_POLY : 8'h00);
  endfunction

  // Packet FIFO storage and pointers
  logic [23:0]      r_hdr_mem [BUF_DEPTH];
  logic [223:0]     r_sub_mem [BUF_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [2:0]       r_count;

  // Slot state
  logic [4:0]   r_counter;
  logic [23:0]  r_act_hdr;
  logic [223:0] r_act_sub;
  logic [7:0]   r_ecc_h;

  logic         w_slot_start;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;
  logic         w_last_pix;
  logic [23:0]  w_cur_hdr;
  logic [223:0] w_cur_sub;
  logic [23:0]  w_hdr;
  logic [223:0] w_sub;
  logic [31:0]  w_bch4;
  logic         w_hdr_bit;
  logic [3:0]   w_even;
  logic [3:0]   w_odd;

  assign in_ready     = (r_count < DEPTH_C);
  assign w_empty      = (r_count == 3'd0);
  assign w_slot_start = data_island_period && (r_counter == 5'd0);
  assign w_push       = in_valid && in_ready;
  assign w_pop        = w_slot_start && !w_empty;
  assign w_last_pix   = (r_counter == LAST_PIX);

  // At slot start the new packet is used directly so pixel 0 has no latency.
  assign w_cur_hdr = w_empty ? NULL_HEADER : r_hdr_mem[r_rd_ptr];
  assign w_cur_sub = w_empty ? 224'd0      : r_sub_mem[r_rd_ptr];
  assign w_hdr     = w_slot_start ? w_cur_hdr : r_act_hdr;
  assign w_sub     = w_slot_start ? w_cur_sub : r_act_sub;

  // ECC sits above the payload so one index covers data and parity pixels.
  assign w_bch4    = {r_ecc_h, w_hdr};
  assign w_hdr_bit = w_bch4[r_counter];

  assign counter      = data_island_period ? r_counter : 5'd0;
  assign packet_start = w_slot_start;
  assign packet_data  = (data_island_period && !reset) ? {w_odd, w_even, w_hdr_bit} : 9'd0;

  // FIFO write port; entries are invalidated by the pointers, not cleared.
  always_ff @(posedge clk_pixel) begin
    if (w_push) begin
      r_hdr_mem[r_wr_ptr] <= in_header;
      r_sub_mem[r_wr_ptr] <= in_sub;
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 3'd1;
      else if (w_pop && !w_push) r_count <= r_count - 3'd1;
    end
  end

  // Pixel counter within the slot, held at zero outside islands.
  always_ff @(posedge clk_pixel) begin
    if (reset || !data_island_period) r_counter <= 5'd0;
    else                              r_counter <= r_counter + 5'd1;
  end

  // Capture the packet being sent for the remaining 31 pixels of the slot.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_act_hdr <= 24'd0;
      r_act_sub <= 224'd0;
    end else if (w_slot_start) begin
      r_act_hdr <= w_cur_hdr;
      r_act_sub <= w_cur_sub;
    end
  end

  // Header ECC absorbs the 24 header bits, then holds for the parity pixels.
  always_ff @(posedge clk_pixel) begin
    if (reset || !data_island_period || w_last_pix) r_ecc_h <= 8'd0;
    else if (r_counter < HDR_BITS)                  r_ecc_h <= ecc_step(r_ecc_h, w_hdr_bit);
  end

  genvar n;
  generate
    for (n = 0; n < 4; n++) begin : g_sub
      logic [63:0] w_bch;
      logic [7:0]  r_ecc;

      assign w_bch     = {r_ecc, w_sub[56*n +: 56]};
      assign w_even[n] = w_bch[{r_counter, 1'b0}];
      assign w_odd[n]  = w_bch[{r_counter, 1'b1}];

      // Subpacket ECC absorbs two bits per pixel, even bit first.
      always_ff @(posedge clk_pixel) begin
        if (reset || !data_island_period || w_last_pix) r_ecc <= 8'd0;
        else if (r_counter < SUB_PAIRS)                 r_ecc <= ecc_step(ecc_step(r_ecc, w_even[n]), w_odd[n]);
      end
    end
  endgenerate

  // Status: packet count per island and one-cycle event pulses.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      packets_sent <= 5'd0;
      underrun     <= 1'b0;
      truncated    <= 1'b0;
    end else begin
      underrun  <= w_slot_start && w_empty;
      // r_counter is nonzero for exactly one low cycle after a cut-short slot.
      truncated <= !data_island_period && (r_counter != 5'd0);
      if (!data_island_period)                         packets_sent <= 5'd0;
      else if (w_slot_start && packets_sent != 5'd31)  packets_sent <= packets_sent + 5'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_packet_stream_assembler.sv
`default_nettype none
// ============================================================================
// Module : tb_hdmi_packet_stream_assembler
// Brief  : Scoreboard bench for the HDMI packet serialiser. Expected pixel
//          words are queued when a slot starts and popped each island pixel.
// Rev    : 1.0  initial release
// ============================================================================
module tb_hdmi_packet_stream_assembler;

  localparam int DEPTH = 2;

  logic         clk_pixel = 1'b0;
  logic         reset = 1'b1;
  logic         data_island_period = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [23:0]  in_header = 24'd0;
  logic [223:0] in_sub = 224'd0;
  logic [8:0]   packet_data;
  logic [4:0]   counter;
  logic         packet_start;
  logic [4:0]   packets_sent;
  logic         underrun;
  logic         truncated;

  always #5 clk_pixel = ~clk_pixel;

  hdmi_packet_stream_assembler #(
    .ECC_POLY    (8'h83),
    .BUF_DEPTH   (DEPTH),
    .NULL_HEADER (24'h0)
  ) dut (
    .clk_pixel          (clk_pixel),
    .reset              (reset),
    .data_island_period (data_island_period),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_header          (in_header),
    .in_sub             (in_sub),
    .packet_data        (packet_data),
    .counter            (counter),
    .packet_start       (packet_start),
    .packets_sent       (packets_sent),
    .underrun           (underrun),
    .truncated          (truncated)
  );

  typedef struct packed {
    logic [23:0]  hdr;
    logic [223:0] sub;
  } pkt_t;

  pkt_t       pend[$];   // packets waiting to be offered
  pkt_t       mq[$];     // model of the DUT FIFO
  logic [8:0] exp_q[$];  // expected pixel words of the current slot

  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_ctr   = 0;
  int   m_sent  = 0;
  logic m_under = 1'b0;
  logic m_trunc = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bit-serial reference ECC over the first nbits of a vector.
  function automatic logic [7:0] ref_ecc(input logic [63:0] bits, input int nbits);
    logic [7:0] e;
    logic       fb;
    e = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      fb = e[0] ^ bits[i];
      e  = e >> 1;
      if (fb) e = e ^ 8'h83;
    end
    return e;
  endfunction

  // Queue the 32 expected pixel words of one packet.
  task automatic load_packet(input pkt_t p);
    logic [31:0] hb;
    logic [63:0] sb [4];
    logic [55:0] s;
    logic [8:0]  w;
    hb = {ref_ecc({40'd0, p.hdr}, 24), p.hdr};
    for (int n = 0; n < 4; n++) begin
      s     = p.sub[56*n +: 56];
      sb[n] = {ref_ecc({8'd0, s}, 56), s};
    end
    for (int k = 0; k < 32; k++) begin
      w[0] = hb[k];
      for (int n = 0; n < 4; n++) begin
        w[1+n] = sb[n][2*k];
        w[5+n] = sb[n][2*k+1];
      end
      exp_q.push_back(w);
    end
  endtask

  function automatic pkt_t rand_pkt(input logic [23:0] hdr);
    pkt_t p;
    p.hdr = hdr;
    p.sub = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom()};
    return p;
  endfunction

  // One pixel cycle: drive, check at negedge, advance the model, step.
  task automatic tick(input logic isl);
    logic       slot;
    logic       acc;
    logic       was_empty;
    logic [8:0] exp_w;
    pkt_t       cur;
    data_island_period = isl;
    in_valid = (pend.size() > 0);
    if (in_valid) begin
      in_header = pend[0].hdr;
      in_sub    = pend[0].sub;
    end
    @(negedge clk_pixel);
    slot      = isl && (m_ctr == 0);
    acc       = in_valid && (mq.size() < DEPTH);
    was_empty = (mq.size() == 0);
    check_eq("in_ready",     in_ready,     mq.size() < DEPTH);
    check_eq("counter",      counter,      isl ? m_ctr : 0);
    check_eq("packet_start", packet_start, slot);
    check_eq("underrun",     underrun,     m_under);
    check_eq("truncated",    truncated,    m_trunc);
    check_eq("packets_sent", packets_sent, m_sent);
    if (slot) begin
      if (!was_empty) cur = mq.pop_front();
      else            cur = '0;
      load_packet(cur);
    end
    if (isl) begin
      exp_w = exp_q.pop_front();
    end else begin
      exp_w = 9'd0;
      exp_q.delete();
    end
    check_eq("packet_data", packet_data, exp_w);
    m_under = slot && was_empty;
    m_trunc = !isl && (m_ctr != 0);
    if (!isl)                    m_sent = 0;
    else if (slot && m_sent < 31) m_sent++;
    m_ctr = isl ? (m_ctr + 1) % 32 : 0;
    if (acc) mq.push_back(pend.pop_front());
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic tick_reset(input logic isl);
    reset = 1'b1;
    data_island_period = isl;
    in_valid = 1'b0;
    @(posedge clk_pixel);
    #1;
    reset = 1'b0;
    mq.delete();
    exp_q.delete();
    m_ctr   = 0;
    m_sent  = 0;
    m_under = 1'b0;
    m_trunc = 1'b0;
  endtask

  initial begin
    tick_reset(1'b0);
    tick_reset(1'b0);

    // Reset state
    check_eq("rst_in_ready",     in_ready,     1);
    check_eq("rst_counter",      counter,      0);
    check_eq("rst_packet_data",  packet_data,  0);
    check_eq("rst_packets_sent", packets_sent, 0);
    check_eq("rst_underrun",     underrun,     0);
    check_eq("rst_truncated",    truncated,    0);
    repeat (2) tick(1'b0);

    // Empty FIFO: one null packet with an underrun pulse
    repeat (32) tick(1'b1);
    repeat (3) tick(1'b0);

    // Single packet with a known header
    pend.push_back(rand_pkt(24'h0D0282));
    repeat (3) tick(1'b0);
    repeat (32) tick(1'b1);
    repeat (3) tick(1'b0);

    // Three packets back-to-back into a two-deep FIFO, then three slots
    for (int i = 0; i < 3; i++) pend.push_back(rand_pkt(24'h000084 + 24'(i)));
    repeat (4) tick(1'b0);
    repeat (96) tick(1'b1);
    repeat (3) tick(1'b0);

    // 40-pixel island with one packet: null second slot, then truncation
    pend.push_back(rand_pkt(24'h0A1B2C));
    repeat (3) tick(1'b0);
    repeat (40) tick(1'b1);
    repeat (3) tick(1'b0);
    repeat (32) tick(1'b1);
    repeat (2) tick(1'b0);

    // Push coinciding with the slot-start pop at occupancy one
    pend.push_back(rand_pkt(24'h111111));
    repeat (3) tick(1'b0);
    pend.push_back(rand_pkt(24'h222222));
    repeat (64) tick(1'b1);
    repeat (2) tick(1'b0);

    // Reset in the middle of a slot with two packets queued
    for (int i = 0; i < 3; i++) pend.push_back(rand_pkt(24'h300000 + 24'(i)));
    repeat (4) tick(1'b0);
    repeat (17) tick(1'b1);
    check_eq("pre_rst_counter", counter, 17);
    tick_reset(1'b1);
    check_eq("post_rst_counter",     counter,     0);
    check_eq("post_rst_in_ready",    in_ready,    1);
    check_eq("post_rst_packet_data", packet_data, 0);
    repeat (32) tick(1'b1);
    repeat (2) tick(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
